// File: rtl/tdm_poly_mixer.sv
// tdm_poly_mixer
// Mixes a TDM stream of N_VOICES wavetable slots into one output sample per
// frame. A sequencer checks the voice order, a per-voice gain is applied, the
// products are summed, and the frame sum is normalised, saturated and
// optionally converted to offset binary for the DAC.
//
// Pipeline, counted from the edge that accepts a slot:
//   edge 0 : slot capture (sample, enable, gain looked up, frame tags)
//   edge 1 : gain product
//   edge 2 : frame accumulator (+ enabled-voice counter)
//   edge 3 : normalise / saturate / format, out_strobe pulse

module tdm_poly_mixer #(
  parameter int D_W            = 16,
  parameter int N_VOICES       = 4,
  parameter int GAIN_W         = 8,
  parameter int OUT_OFFSET_BIN = 1
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [$clog2(N_VOICES)-1:0]  in_voice,
  input  logic                         in_en,
  input  logic [D_W-1:0]               in_data,
  input  logic                         gain_we,
  input  logic [$clog2(N_VOICES)-1:0]  gain_voice,
  input  logic [GAIN_W-1:0]            gain_val,
  input  logic [1:0]                   norm_mode,
  input  logic                         frame_err_clr,
  output logic [D_W-1:0]               out_data,
  output logic                         out_strobe,
  output logic [$clog2(N_VOICES):0]    active_count,
  output logic                         frame_err
);

  localparam int VN_W  = $clog2(N_VOICES);
  localparam int ACC_W = D_W + VN_W + 1;
  localparam int PRD_W = D_W + GAIN_W + 1;

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [VN_W-1:0] VOICE_ZERO = {VN_W{1'b0}};
  localparam logic [VN_W-1:0] VOICE_ONE  = VN_W'(1);
  localparam logic [VN_W-1:0] LAST_VOICE = VN_W'(N_VOICES - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (D_W - 1)));

  // MSB flip that turns a signed sample into offset binary (zero when signed out).
  localparam logic [D_W-1:0] OFFS_MASK = (OUT_OFFSET_BIN != 0) ?
                                         {1'b1, {(D_W-1){1'b0}}} : {D_W{1'b0}};

  localparam logic [4:0] SH_FULL = 5'(VN_W);
  localparam logic [4:0] SH_NONE = 5'd0;
  localparam logic [4:0] SH_HALF = 5'd1;

  // Clamp a wide signed value into the D_W-bit signed range.
  function automatic logic [D_W-1:0] sat_to_dw(input logic signed [ACC_W-1:0] v);
    logic [D_W-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[D_W-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[D_W-1:0];
    end else begin
      r = D_W'(v);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Gain table
  // ---------------------------------------------------------------------------
  logic [GAIN_W-1:0] gain_q [N_VOICES];

  // Per-voice gain storage; a write lands at the edge, so a slot of the same
  // voice in the same cycle still reads the old gain.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_VOICES; i++) begin
        gain_q[i] <= {GAIN_W{1'b1}};
      end
    end else if (gain_we) begin
      gain_q[gain_voice] <= gain_val;
    end else begin
      for (int i = 0; i < N_VOICES; i++) begin
        gain_q[i] <= gain_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Slot sequencer
  // ---------------------------------------------------------------------------
  logic [0:0]      state_q, state_d;
  logic [VN_W-1:0] exp_q, exp_d;
  logic            take_s;   // slot belongs to the frame being built
  logic            first_s;  // slot opens a frame (accumulator loads)
  logic            last_s;   // slot completes a frame
  logic            err_s;    // out-of-order slot seen while running

  // Next-state logic for the expected-voice tracker.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    take_s  = 1'b0;
    first_s = 1'b0;
    last_s  = 1'b0;
    err_s   = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_SYNC: begin
          if (in_voice == VOICE_ZERO) begin
            take_s  = 1'b1;
            first_s = 1'b1;
            state_d = ST_RUN;
            exp_d   = VOICE_ONE;
          end else begin
            state_d = ST_SYNC;
            exp_d   = VOICE_ZERO;
          end
        end
        ST_RUN: begin
          if (in_voice == exp_q) begin
            take_s = 1'b1;
            if (exp_q == LAST_VOICE) begin
              last_s  = 1'b1;
              state_d = ST_SYNC;
              exp_d   = VOICE_ZERO;
            end else begin
              exp_d = exp_q + VOICE_ONE;
            end
          end else begin
            // The partial frame is dropped simply by never tagging it complete;
            // a voice-0 slot reopens a frame straight away.
            err_s = 1'b1;
            if (in_voice == VOICE_ZERO) begin
              take_s  = 1'b1;
              first_s = 1'b1;
              state_d = ST_RUN;
              exp_d   = VOICE_ONE;
            end else begin
              state_d = ST_SYNC;
              exp_d   = VOICE_ZERO;
            end
          end
        end
        default: begin
          state_d = ST_SYNC;
          exp_d   = VOICE_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
      exp_d   = exp_q;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      exp_q   <= VOICE_ZERO;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
    end
  end

  // Sticky frame error; a same-cycle error wins over the clear.
  logic frame_err_q;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else if (err_s) begin
      frame_err_q <= 1'b1;
    end else if (frame_err_clr) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge 0: slot capture
  // ---------------------------------------------------------------------------
  logic              s0_vld_q, s0_first_q, s0_last_q, s0_en_q;
  logic [D_W-1:0]    s0_data_q;
  logic [GAIN_W-1:0] s0_gain_q;

  // Capture accepted slots together with the gain in force before any write.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q   <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_en_q    <= 1'b0;
      s0_data_q  <= {D_W{1'b0}};
      s0_gain_q  <= {GAIN_W{1'b0}};
    end else if (take_s) begin
      s0_vld_q   <= 1'b1;
      s0_first_q <= first_s;
      s0_last_q  <= last_s;
      s0_en_q    <= in_en;
      s0_data_q  <= in_data;
      s0_gain_q  <= gain_q[in_voice];
    end else begin
      s0_vld_q   <= 1'b0;
      s0_first_q <= s0_first_q;
      s0_last_q  <= s0_last_q;
      s0_en_q    <= s0_en_q;
      s0_data_q  <= s0_data_q;
      s0_gain_q  <= s0_gain_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge 1: gain product, floor((sample * gain) / 2^GAIN_W)
  // ---------------------------------------------------------------------------
  logic signed [PRD_W-1:0] data_ext_s, gain_ext_s, prod_full_s;
  logic signed [D_W-1:0]   p1_prod_d;

  // Signed sample times unsigned gain; the arithmetic shift floors, and the
  // result always fits D_W since the gain is below 2^GAIN_W.
  always_comb begin
    data_ext_s  = PRD_W'($signed(s0_data_q));
    gain_ext_s  = $signed(PRD_W'({1'b0, s0_gain_q}));
    prod_full_s = data_ext_s * gain_ext_s;
    if (s0_en_q) begin
      p1_prod_d = D_W'(prod_full_s >>> GAIN_W);
    end else begin
      p1_prod_d = {D_W{1'b0}};
    end
  end

  logic                  p1_vld_q, p1_first_q, p1_last_q, p1_en_q;
  logic signed [D_W-1:0] p1_prod_q;

  // Product stage register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_en_q    <= 1'b0;
      p1_prod_q  <= {D_W{1'b0}};
    end else if (s0_vld_q) begin
      p1_vld_q   <= 1'b1;
      p1_first_q <= s0_first_q;
      p1_last_q  <= s0_last_q;
      p1_en_q    <= s0_en_q;
      p1_prod_q  <= p1_prod_d;
    end else begin
      p1_vld_q   <= 1'b0;
      p1_first_q <= p1_first_q;
      p1_last_q  <= p1_last_q;
      p1_en_q    <= p1_en_q;
      p1_prod_q  <= p1_prod_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge 2: frame accumulator; VN_W+1 guard bits cannot overflow
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] acc_q;
  logic [VN_W:0]           cnt_q;
  logic                    done_q;

  // Load on the frame's first slot, add afterwards; flag the completed frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= {ACC_W{1'b0}};
      cnt_q  <= {(VN_W+1){1'b0}};
      done_q <= 1'b0;
    end else if (p1_vld_q) begin
      if (p1_first_q) begin
        acc_q <= ACC_W'(p1_prod_q);
        cnt_q <= (VN_W+1)'(p1_en_q);
      end else begin
        acc_q <= acc_q + ACC_W'(p1_prod_q);
        cnt_q <= cnt_q + (VN_W+1)'(p1_en_q);
      end
      done_q <= p1_last_q;
    end else begin
      acc_q  <= acc_q;
      cnt_q  <= cnt_q;
      done_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge 3: normalise, saturate, format
  // ---------------------------------------------------------------------------
  logic [4:0]              shamt_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic [D_W-1:0]          fmt_s;

  // Shift chosen by norm_mode, then clamp and apply the DAC format.
  always_comb begin
    case (norm_mode)
      2'd0:    shamt_s = SH_FULL;
      2'd1:    shamt_s = SH_NONE;
      2'd2:    shamt_s = SH_HALF;
      2'd3:    shamt_s = SH_FULL;
      default: shamt_s = SH_FULL;
    endcase
    shifted_s = acc_q >>> shamt_s;
    fmt_s     = sat_to_dw(shifted_s) ^ OFFS_MASK;
  end

  logic [D_W-1:0] out_data_q;
  logic           out_strobe_q;
  logic [VN_W:0]  active_count_q;

  // Output registers; out_data and active_count hold between strobes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q     <= OFFS_MASK;
      out_strobe_q   <= 1'b0;
      active_count_q <= {(VN_W+1){1'b0}};
    end else if (done_q) begin
      out_data_q     <= fmt_s;
      out_strobe_q   <= 1'b1;
      active_count_q <= cnt_q;
    end else begin
      out_data_q     <= out_data_q;
      out_strobe_q   <= 1'b0;
      active_count_q <= active_count_q;
    end
  end

  assign out_data     = out_data_q;
  assign out_strobe   = out_strobe_q;
  assign active_count = active_count_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_tdm_poly_mixer.sv
// Directed bench for tdm_poly_mixer (default parameters, offset-binary output).
// Expected values are hand-computed: a 0x1000 slot at gain 255 gives
// floor(4096*255/256) = 4080 per voice.

module tb_tdm_poly_mixer;

  logic        sys_clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  in_voice;
  logic        in_en;
  logic [15:0] in_data;
  logic        gain_we;
  logic [1:0]  gain_voice;
  logic [7:0]  gain_val;
  logic [1:0]  norm_mode;
  logic        frame_err_clr;
  logic [15:0] out_data;
  logic        out_strobe;
  logic [2:0]  active_count;
  logic        frame_err;

  int  n_checks = 0;
  int  n_errors = 0;
  int  strobe_cnt = 0;
  logic [15:0] st_data = 16'h0;
  logic [2:0]  st_act = 3'd0;
  time st_time = 0;
  time t_acc = 0;

  tdm_poly_mixer dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_voice      (in_voice),
    .in_en         (in_en),
    .in_data       (in_data),
    .gain_we       (gain_we),
    .gain_voice    (gain_voice),
    .gain_val      (gain_val),
    .norm_mode     (norm_mode),
    .frame_err_clr (frame_err_clr),
    .out_data      (out_data),
    .out_strobe    (out_strobe),
    .active_count  (active_count),
    .frame_err     (frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (out_strobe === 1'b1) begin
      strobe_cnt = strobe_cnt + 1;
      st_data    = out_data;
      st_act     = active_count;
      st_time    = $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one slot for one cycle; t_acc records the accepting edge.
  task automatic slot(input int v, input logic en, input logic [15:0] d);
    in_valid = 1'b1;
    in_voice = 2'(v);
    in_en    = en;
    in_data  = d;
    @(posedge sys_clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    gain_we  = 1'b0;
  endtask

  // One frame 0..3; optional idle gap after voice 1 and optional gain write
  // (value gw_val to voice gw_at) in the same cycle as slot gw_at.
  task automatic run_frame(input string tag, input logic [15:0] d, input logic [3:0] en,
                           input int gap, input int gw_at, input logic [7:0] gw_val,
                           input logic [15:0] exp_data, input logic [2:0] exp_act);
    int n0;
    n0 = strobe_cnt;
    for (int v = 0; v < 4; v++) begin
      if (v == gw_at) begin
        gain_we    = 1'b1;
        gain_voice = 2'(v);
        gain_val   = gw_val;
      end
      slot(v, en[v], d);
      if (v == 1 && gap > 0) begin
        repeat (gap) @(posedge sys_clk);
        #1;
      end
    end
    repeat (8) @(negedge sys_clk);
    chk({tag, "_strobes"}, 32'(strobe_cnt - n0), 32'd1);
    chk({tag, "_data"}, {16'h0, st_data}, {16'h0, exp_data});
    chk({tag, "_active"}, {29'h0, st_act}, {29'h0, exp_act});
    chk({tag, "_latency"}, 32'(st_time - t_acc), 32'd35);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_voice = 2'd0; in_en = 1'b0; in_data = 16'h0;
    gain_we = 1'b0; gain_voice = 2'd0; gain_val = 8'h0;
    norm_mode = 2'd0; frame_err_clr = 1'b0;

    #12;
    chk("rst_data", {16'h0, out_data}, 32'h8000);
    chk("rst_strobe", {31'h0, out_strobe}, 32'h0);
    chk("rst_active", {29'h0, active_count}, 32'h0);
    chk("rst_err", {31'h0, frame_err}, 32'h0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // mode 0, all enabled: 16320 >> 2 = 4080 -> 0x8FF0
    norm_mode = 2'd0;
    run_frame("m0_all", 16'h1000, 4'b1111, 0, -1, 8'h0, 16'h8FF0, 3'd4);

    // mode 1 saturation both ways
    norm_mode = 2'd1;
    run_frame("sat_pos", 16'h7000, 4'b1111, 0, -1, 8'h0, 16'hFFFF, 3'd4);
    run_frame("sat_neg", 16'h9000, 4'b1111, 0, -1, 8'h0, 16'h0000, 3'd4);

    // voices 1 and 3 disabled: 8160 >> 2 = 2040 -> 0x87F8
    norm_mode = 2'd0;
    run_frame("half_en", 16'h1000, 4'b0101, 0, -1, 8'h0, 16'h87F8, 3'd2);

    // mode 2: 16320 >> 1 = 8160 -> 0x9FE0, with a stall mid-frame
    norm_mode = 2'd2;
    run_frame("m2_stall", 16'h1000, 4'b1111, 2, -1, 8'h0, 16'h9FE0, 3'd4);

    // slot order 0,1,3 -> error, no strobe
    norm_mode = 2'd0;
    n0 = strobe_cnt;
    slot(0, 1'b1, 16'h1000);
    slot(1, 1'b1, 16'h1000);
    slot(3, 1'b1, 16'h1000);
    repeat (8) @(negedge sys_clk);
    chk("err_set", {31'h0, frame_err}, 32'h1);
    chk("err_nostrobe", 32'(strobe_cnt - n0), 32'd0);
    run_frame("err_clean", 16'h1000, 4'b1111, 1, -1, 8'h0, 16'h8FF0, 3'd4);
    chk("err_sticky", {31'h0, frame_err}, 32'h1);
    frame_err_clr = 1'b1;
    @(posedge sys_clk); #1;
    frame_err_clr = 1'b0;
    chk("err_clr", {31'h0, frame_err}, 32'h0);

    // gain write to voice 2 alongside its slot: old gain this frame
    norm_mode = 2'd1;
    run_frame("gain_old", 16'h1000, 4'b1111, 0, 2, 8'h00, 16'hBFC0, 3'd4);
    run_frame("gain_new", 16'h1000, 4'b1111, 0, -1, 8'h0, 16'hAFD0, 3'd4);

    // reset mid-frame after voice 1
    norm_mode = 2'd0;
    slot(0, 1'b1, 16'h1000);
    slot(1, 1'b1, 16'h1000);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", {16'h0, out_data}, 32'h8000);
    chk("mid_rst_active", {29'h0, active_count}, 32'h0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    n0 = strobe_cnt;
    slot(1, 1'b1, 16'h1000);
    slot(2, 1'b1, 16'h1000);
    slot(3, 1'b1, 16'h1000);
    for (int v = 0; v < 4; v++) begin
      slot(v, 1'b1, 16'h1000);
    end
    repeat (8) @(negedge sys_clk);
    chk("post_rst_strobes", 32'(strobe_cnt - n0), 32'd1);
    chk("post_rst_data", {16'h0, st_data}, 32'h8FF0);
    chk("post_rst_latency", 32'(st_time - t_acc), 32'd35);
    chk("post_rst_err", {31'h0, frame_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
